// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the rr_arbiter_n slice: FSM state encoding,
// index-width helper and priority-mode encodings.
package rr_arb_pkg;

  localparam int RR_MODE_FIXED = 0;
  localparam int RR_MODE_RR    = 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY
  } arb_state_e;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter_n_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_arbiter_n_if #(
  parameter int N_REQ = 4
);
  import rr_arb_pkg::*;

  localparam int IW = idx_w(N_REQ);

  // req is level-sensitive and sampled only at rising edges; a requester
  // keeps its bit high for as long as it wants the resource. gnt is registered,
  // one-hot or zero, and stays with its owner until that owner drops req.
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic             gnt_valid;
  logic [IW-1:0]    gnt_id;

  modport master (output req, input gnt, gnt_valid, gnt_id);
  modport slave  (input req, output gnt, gnt_valid, gnt_id);

endinterface

// File: rtl/rr_arb_pick.sv
// Combinational circular priority search: first set bit of req_i at or after
// start_i, wrapping from N_REQ-1 back to 0.
module rr_arb_pick
  import rr_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    start_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand = IW'((int'(start_i) + off) % N_REQ);
      if (!any_o && req_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// N-way arbiter with round-robin or fixed priority and registered grants.
// Optional hold limit enabled by defining RR_ARB_HOLD_LIMIT_EN.
module rr_arbiter_n
  import rr_arb_pkg::*;
#(
  parameter  int N_REQ    = 4,
  parameter  int RR_MODE  = 1,
  parameter  int MAX_HOLD = 8,
  localparam int IW       = idx_w(N_REQ)
) (
  input  logic                 clock,
  input  logic                 reset,
  rr_arbiter_n_if.slave        bus,
  output arb_state_e           dbg_state_o,
  output logic [IW-1:0]        dbg_last_owner_o
);

  if (N_REQ < 2 || N_REQ > 16 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
    $error("rr_arbiter_n: N_REQ or MAX_HOLD out of range");
  end

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IW-1:0]    gnt_id_q, gnt_id_d;
  logic [IW-1:0]    last_q, last_d;

  logic [N_REQ-1:0] pick_req;
  logic [IW-1:0]    start_idx;
  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             owner_req;
  logic             force_rearb;
  logic             take_new;
  logic             go_idle;

  // The current owner never competes: in IDLE gnt_q is zero, in BUSY the owner
  // either released or is being pushed out by the hold limit.
  assign pick_req  = bus.req & ~gnt_q;
  assign owner_req = |(bus.req & gnt_q);
  assign start_idx = (RR_MODE == RR_MODE_RR)
                   ? ((last_q == IW'(N_REQ - 1)) ? '0 : last_q + 1'b1)
                   : '0;

  rr_arb_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i   (pick_req),
    .start_i (start_idx),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

`ifdef RR_ARB_HOLD_LIMIT_EN
  logic [7:0] hold_cnt_q, hold_cnt_d;

  assign force_rearb = (state_q == BUSY) && (hold_cnt_q == 8'(MAX_HOLD)) && pick_any;

  // Counts cycles the current grant has been visible; saturates at MAX_HOLD.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (take_new) begin
      hold_cnt_d = 8'd1;
    end else if (go_idle) begin
      hold_cnt_d = '0;
    end else if (state_q == BUSY && hold_cnt_q < 8'(MAX_HOLD)) begin
      hold_cnt_d = hold_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) hold_cnt_q <= '0;
    else       hold_cnt_q <= hold_cnt_d;
  end
`else
  assign force_rearb = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    last_d      = last_q;
    take_new    = 1'b0;
    go_idle     = 1'b0;
    case (state_q)
      IDLE: take_new = pick_any;
      BUSY: begin
        if (!owner_req || force_rearb) begin
          take_new = pick_any;
          go_idle  = !pick_any;
        end
      end
      default: go_idle = 1'b1;
    endcase
    if (take_new) begin
      state_d     = BUSY;
      gnt_d       = pick_gnt;
      gnt_valid_d = 1'b1;
      gnt_id_d    = pick_idx;
      last_d      = pick_idx;
    end else if (go_idle) begin
      state_d     = IDLE;
      gnt_d       = '0;
      gnt_valid_d = 1'b0;
      gnt_id_d    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      last_q      <= IW'(N_REQ - 1);
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      last_q      <= last_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.gnt_valid    = gnt_valid_q;
  assign bus.gnt_id       = gnt_id_q;
  assign dbg_state_o      = state_q;
  assign dbg_last_owner_o = last_q;

endmodule

// File: doc/rr_arbiter_n.md
RR_ARBITER_N -- requirements
Module: rr_arbiter_n

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter RR_MODE, default 1: 1 selects round-robin priority; 0 selects fixed priority with index 0 highest.
REQ-003 Parameter MAX_HOLD, default 8: maximum consecutive grant cycles per owner; legal range 2..255; used only under REQ-020.
REQ-004 clock  input  1  clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  N_REQ  request vector; bit i high means requester i wants the resource.
REQ-007 gnt  output  N_REQ  one-hot or all-zero grant vector, registered.
REQ-008 gnt_valid  output  1  high when any gnt bit is high, registered.
REQ-009 gnt_id  output  clog2(N_REQ)  index of the granted requester, registered; value is 0 when gnt_valid is low.

Function
REQ-010 The FSM SHALL have two states: IDLE (no owner) and BUSY (one owner holds the grant).
REQ-011 IDLE, req nonzero at an edge: the block SHALL select a winner per REQ-013/014, set gnt for that winner, and go to BUSY; grant is visible one cycle after the request is sampled.
REQ-012 BUSY: while req[owner] stays high, gnt SHALL be held unchanged, including when other requests arrive (no preemption, except under REQ-020).
REQ-013 RR_MODE=1: the search SHALL start at index (last_owner+1) mod N_REQ and wrap from N_REQ-1 to 0; last_owner resets to N_REQ-1, so index 0 wins first.
REQ-014 RR_MODE=0: the lowest-indexed asserted req bit SHALL win.
REQ-015 BUSY, req[owner] sampled low: if other requests are pending, the next winner SHALL be granted at the same edge (no idle bubble); otherwise gnt SHALL clear and the FSM SHALL go to IDLE.
REQ-016 At most one gnt bit SHALL be high in any cycle; gnt_valid SHALL equal OR(gnt), and gnt_id SHALL encode gnt.
REQ-017 Simultaneous requests in IDLE SHALL resolve in a single cycle by the active priority rule.
REQ-018 A request asserted and released between edges SHALL be ignored; a request is recognised only at a rising edge.

Reset
REQ-019 While reset is high at an edge: gnt=0, gnt_valid=0, gnt_id=0, state=IDLE, last_owner=N_REQ-1, hold counter=0; reset during BUSY SHALL drop the grant after that edge.

Configuration
REQ-020 With RR_ARB_HOLD_LIMIT_EN defined, the block SHALL count consecutive BUSY cycles of the current owner. When the count reaches MAX_HOLD and any other req bit is high, the block SHALL force re-arbitration at the next edge, excluding the current owner from that arbitration. The counter SHALL reset on every grant change. If no other request is pending, the owner SHALL keep the grant and the counter SHALL saturate.
REQ-021 Without RR_ARB_HOLD_LIMIT_EN, the block SHALL contain no hold counter and ownership SHALL end only by release or reset.

Structure
REQ-022 A shared package rr_arb_pkg SHALL hold the state enum (IDLE, BUSY), the clog2-based index width function, and the RR_MODE encoding constants.
REQ-023 The priority search SHALL be a combinational sub-module rr_arb_pick (inputs: request vector, start index; outputs: one-hot winner, index, any); it SHALL be instantiated once.

Verification (N_REQ=4, MAX_HOLD=4)
REQ-024 Reset: hold reset 2 cycles with req=4'b1111 -> gnt=0, gnt_valid=0 throughout; one cycle after release, gnt=4'b0001 and gnt_id=0.
REQ-025 Round-robin rotation: req=4'b1111 held; each owner releases after 1 cycle -> grant sequence 0001,0010,0100,1000,0001 with no bubble.
REQ-026 Fixed priority (RR_MODE=0): req=4'b1010 -> gnt=0010; release bit1 -> gnt=1000 on the next cycle; then assert bit0 -> 1000 is held, with no preemption.
REQ-027 Wrap-around: last_owner=3, req=4'b0101 -> gnt=0001; with last_owner=0, the same req -> gnt=0100.
REQ-028 Hold limit (RR_ARB_HOLD_LIMIT_EN): req0 held, req2 asserted -> gnt=0001 for 4 cycles, then 0100; with req2 absent, 0001 is held indefinitely.
REQ-029 Mid-operation reset: reset asserted in BUSY with gnt=0100 -> gnt=0 after the edge; after reset releases, arbitration restarts from index 0.
